// File: rtl/rf_port_ctrl.sv
// Register-file port controller: clears all 32 registers after reset, then
// arbitrates the write port between the pipeline write-back and a debug monitor,
// and steals read port 1 for debug reads while the CPU is halted.
module rf_port_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    // pipeline write-back request
    input  logic        wb_wen,
    input  logic [4:0]  wb_wadr,
    input  logic [31:0] wb_wdata,
    // pipeline read address, port 1
    input  logic [4:0]  id_radr1,
    // high while the pipeline executes
    input  logic        cpu_run,
    // debug-monitor access
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_adr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    // register-file write port
    output logic        ram_wen,
    output logic [4:0]  ram_wadr,
    output logic [31:0] ram_wdata,
    // register-file read port 1 (address registered inside the RAM)
    output logic [4:0]  ram_radr1,
    input  logic [31:0] ram_rdata1,
    output logic        init_done
);

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        IDLE    = 2'd1,
        DBG_RD  = 2'd2,
        DBG_ACK = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        init_done_q, init_done_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;

    logic        wen_c;
    logic [4:0]  wadr_c;
    logic [31:0] wdata_c;
    logic [4:0]  radr_c;

    // State, clear counter, init flag and captured debug read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cnt_q       <= 5'd0;
            init_done_q <= 1'b0;
            dbg_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Next-state decode and write/read port steering.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        dbg_rdata_d = dbg_rdata_q;
        wen_c       = 1'b0;
        wadr_c      = wb_wadr;
        wdata_c     = wb_wdata;
        radr_c      = id_radr1;

        case (state_q)
            INIT: begin
                // Sweep every address with zero; pipeline and debug are ignored.
                wen_c   = 1'b1;
                wadr_c  = cnt_q;
                wdata_c = 32'd0;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            IDLE: begin
                wen_c = wb_wen && (wb_wadr != 5'd0);
                if (dbg_req && !cpu_run) begin
                    if (dbg_we) begin
                        // A debug write only goes when the pipeline leaves the port free.
                        if (!wb_wen) begin
                            wen_c   = (dbg_adr != 5'd0);
                            wadr_c  = dbg_adr;
                            wdata_c = dbg_wdata;
                            state_d = DBG_ACK;
                        end
                    end else begin
                        // Read address is latched by the RAM this cycle; data arrives in DBG_RD.
                        radr_c  = dbg_adr;
                        state_d = DBG_RD;
                    end
                end
            end
            DBG_RD: begin
                wen_c       = wb_wen && (wb_wadr != 5'd0);
                dbg_rdata_d = ram_rdata1;
                state_d     = DBG_ACK;
            end
            DBG_ACK: begin
                wen_c   = wb_wen && (wb_wadr != 5'd0);
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase

        // Keep the RAM quiet while reset is held, even though state already reads INIT.
        if (!rst_n) begin
            wen_c   = 1'b0;
            wadr_c  = 5'd0;
            wdata_c = 32'd0;
            radr_c  = id_radr1;
        end
    end

    assign ram_wen   = wen_c;
    assign ram_wadr  = wadr_c;
    assign ram_wdata = wdata_c;
    assign ram_radr1 = radr_c;
    assign dbg_ack   = (state_q == DBG_ACK);
    assign dbg_rdata = dbg_rdata_q;
    assign init_done = init_done_q;

endmodule

// File: doc/rf_port_ctrl.md
RF_PORT_CTRL -- requirements
Module: rf_port_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  system clock (all state on rising edge).
REQ-002 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: wb_wen / wb_wadr / wb_wdata  input  1/5/32  pipeline write-back request.
REQ-004 SHALL have ports: id_radr1  input  5  pipeline read address, port 1.
REQ-005 SHALL have ports: cpu_run  input  1  high while the pipeline executes; debug access only allowed when low.
REQ-006 SHALL have ports: dbg_req / dbg_we / dbg_adr / dbg_wdata  input  1/1/5/32  debug-monitor access request.
REQ-007 SHALL have ports: dbg_ack  output  1  one-cycle completion pulse; dbg_rdata  output  32  registered read data.
REQ-008 SHALL have ports: ram_wen / ram_wadr / ram_wdata  output  1/5/32  to register-file write port.
REQ-009 SHALL have ports: ram_radr1  output  5  to register-file read port 1 (RAM registers the address; data valid the following cycle).
REQ-010 SHALL have ports: init_done  output  1  high once all 32 registers are cleared; pipeline holds while low.

Function
REQ-011 SHALL implement FSM states INIT, IDLE, DBG_RD, DBG_ACK.
REQ-012 SHALL, in INIT, drive ram_wen=1, ram_wdata=0, ram_wadr=5-bit counter, incrementing 0..31 one per cycle.
REQ-013 SHALL, after the cycle writing address 31, go to IDLE and set init_done=1 (32 cycles after reset release); init_done stays 1 until next reset.
REQ-014 SHALL, in INIT, ignore wb_wen and dbg_req (no ack, no write).
REQ-015 SHALL, outside INIT, give the write port to the pipeline whenever wb_wen=1: ram_wen/ram_wadr/ram_wdata = wb_* combinationally.
REQ-016 SHALL suppress writes to address 0 from any source outside INIT (ram_wen=0 when target address is 0).
REQ-017 SHALL accept a debug request only in IDLE with dbg_req=1, cpu_run=0, and (for writes) wb_wen=0; otherwise the request waits with no side effects.
REQ-018 SHALL perform an accepted debug write in the accept cycle (ram_wen=1 unless dbg_adr=0, ram_wadr=dbg_adr, ram_wdata=dbg_wdata) and go to DBG_ACK.
REQ-019 SHALL, on an accepted debug read, drive ram_radr1=dbg_adr in the accept cycle and go to DBG_RD; in every other cycle ram_radr1=id_radr1.
REQ-020 SHALL, in DBG_RD, capture the RF read data into dbg_rdata and go to DBG_ACK; the write port stays available to wb_wen in DBG_RD.
REQ-021 SHALL assert dbg_ack=1 for exactly the DBG_ACK cycle, then return to IDLE; dbg_req seen in DBG_ACK is ignored (requester drops it on ack).
REQ-022 SHALL give latency accept→ack of 1 cycle for writes and 2 cycles for reads.
REQ-023 SHALL hold dbg_rdata until the next completed debug read; debug writes do not change it.
REQ-024 SHALL, if cpu_run rises after acceptance, still complete the debug access.

Reset
REQ-025 SHALL, on rst_n low, asynchronously enter INIT with counter=0, init_done=0, dbg_ack=0, dbg_rdata=0.
REQ-026 SHALL drive, while rst_n is low, ram_wen=0, ram_wadr=0, ram_wdata=0, ram_radr1=id_radr1.
REQ-027 SHALL, on reset mid-INIT or mid-debug access, abort it without ack and restart clearing from address 0 after release.

Verification
REQ-028 SHALL be checked: release reset -> ram_wen=1 with addresses 0..31, data 0, for 32 cycles; init_done rises the next cycle; wb_wen pulsed during INIT produces no write.
REQ-029 SHALL be checked: cpu_run=0, debug write adr=5 data=0xDEADBEEF -> ram_wen same cycle, dbg_ack next cycle; debug read adr=5 -> dbg_ack 2 cycles after accept, dbg_rdata=0xDEADBEEF.
REQ-030 SHALL be checked: wb_wen=1 (adr=3) and debug write same cycle -> pipeline write occurs, debug write occurs the cycle after wb_wen drops.
REQ-031 SHALL be checked: cpu_run=1 with dbg_req=1 for 10 cycles -> no ack, ram_radr1 tracks id_radr1; cpu_run falls -> access completes.
REQ-032 SHALL be checked: write 0x1234 to adr 0 via pipeline and debug -> ram_wen stays 0; debug read adr 0 returns 0.
REQ-033 SHALL be checked: assert rst_n low during DBG_RD or at INIT counter=17 -> no dbg_ack, clearing restarts at address 0.
